mem_writeback: RTL and testbench

Final pipeline stage of the three-stage RV32I core; it sits directly after the execute stage. It registers the execute-stage result, performs the data-memory access for loads and stores over a valid/ready request channel, and aligns and sign-extends load data. It drives the register-file write port, which is also the forwarding source (`previous`, `prev_rd`, `prev_reg_we`) consumed by execute. It asserts `stall` to freeze upstream stages while a memory access is outstanding.

---
 rtl/mem_writeback.sv | 207 ++++++++++++++++++++
 tb/tb_mem_writeback.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_writeback.sv
// -----------------------------------------------------------------------------
// mem_writeback -- final stage of the three-stage RV32I pipeline.
//
// Registers the execute-stage result into stage register M, performs the data
// memory access (valid/ready request, one response per accepted load), aligns
// and sign/zero-extends load data, and drives the register-file write port,
// which doubles as the forwarding source for execute.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   ex_*                : instruction presented by execute (captured when !stall)
//   stall               : freeze execute and earlier stages
//   dmem_req_*          : request channel (addr word-aligned, we, wdata, wmask)
//   dmem_resp_*         : load response, valid for one cycle
//   previous, prev_rd,
//   prev_reg_we         : writeback / forwarding data, destination, enable
// -----------------------------------------------------------------------------
module mem_writeback (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_we,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_funct3,
  output logic        stall,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wmask,
  input  logic        dmem_resp_valid,
  input  logic [31:0] dmem_resp_data,
  output logic [31:0] previous,
  output logic [4:0]  prev_rd,
  output logic        prev_reg_we
);

  typedef enum logic [0:0] {
    ST_ISSUE = 1'b0,
    ST_WAIT  = 1'b1
  } state_e;

  state_e      state_q, state_d;

  logic        m_valid_q, m_valid_d;
  logic [31:0] m_result_q, m_result_d;
  logic [31:0] m_store_data_q, m_store_data_d;
  logic [4:0]  m_rd_q, m_rd_d;
  logic        m_reg_we_q, m_reg_we_d;
  logic        m_is_load_q, m_is_load_d;
  logic        m_is_store_q, m_is_store_d;
  logic [2:0]  m_funct3_q, m_funct3_d;

  logic        m_load_s;
  logic        m_store_s;
  logic        rd_nonzero_s;

  // Replicate the store operand across all lanes; the mask selects the lanes.
  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] data);
    logic [31:0] res;
    case (f3)
      3'b000:  res = {4{data[7:0]}};
      3'b001:  res = {2{data[15:0]}};
      default: res = data;
    endcase
    return res;
  endfunction

  // Byte-lane enables; misaligned low address bits are simply dropped.
  function automatic logic [3:0] store_wmask(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] res;
    case (f3)
      3'b000:  res = 4'b0001 << lo;
      3'b001:  res = 4'b0011 << {lo[1], 1'b0};
      default: res = 4'b1111;
    endcase
    return res;
  endfunction

  // Select the addressed byte/half of the response word and extend it.
  function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] data);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = data[{lo, 3'b000} +: 8];
    h = lo[1] ? data[31:16] : data[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b100:  res = {24'h000000, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b101:  res = {16'h0000, h};
      default: res = data;
    endcase
    return res;
  endfunction

  assign m_load_s     = m_valid_q & m_is_load_q;
  assign m_store_s    = m_valid_q & m_is_store_q;
  assign rd_nonzero_s = (m_rd_q != 5'd0);

  // Stage register next state: capture execute unless stalled.
  always_comb begin
    m_valid_d      = m_valid_q;
    m_result_d     = m_result_q;
    m_store_data_d = m_store_data_q;
    m_rd_d         = m_rd_q;
    m_reg_we_d     = m_reg_we_q;
    m_is_load_d    = m_is_load_q;
    m_is_store_d   = m_is_store_q;
    m_funct3_d     = m_funct3_q;
    if (!stall) begin
      m_valid_d      = ex_valid;
      m_result_d     = ex_result;
      m_store_data_d = ex_store_data;
      m_rd_d         = ex_rd;
      m_reg_we_d     = ex_reg_we;
      m_is_load_d    = ex_is_load;
      m_is_store_d   = ex_is_store;
      m_funct3_d     = ex_funct3;
    end else begin
      m_valid_d      = m_valid_q;
    end
  end

  // Access FSM: request handshake, stall generation and writeback enable.
  always_comb begin
    state_d        = state_q;
    dmem_req_valid = 1'b0;
    stall          = 1'b0;
    prev_reg_we    = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        if (m_load_s) begin
          // A load always occupies at least one more cycle for its response.
          dmem_req_valid = 1'b1;
          stall          = 1'b1;
          if (dmem_req_ready) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_ISSUE;
          end
        end else if (m_store_s) begin
          // Stores are posted: done as soon as the request is accepted.
          dmem_req_valid = 1'b1;
          stall          = ~dmem_req_ready;
        end else begin
          prev_reg_we = m_valid_q & m_reg_we_q & rd_nonzero_s;
        end
      end
      ST_WAIT: begin
        stall = ~dmem_resp_valid;
        if (dmem_resp_valid) begin
          state_d     = ST_ISSUE;
          prev_reg_we = m_load_s & m_reg_we_q & rd_nonzero_s;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_ISSUE;
      end
    endcase
  end

  // Request fields come straight from M, so they hold while stalled.
  assign dmem_addr  = {m_result_q[31:2], 2'b00};
  assign dmem_we    = m_store_s;
  assign dmem_wdata = store_wdata(m_funct3_q, m_store_data_q);
  assign dmem_wmask = m_store_s ? store_wmask(m_funct3_q, m_result_q[1:0]) : 4'b0000;

  // Load data is forwarded combinationally in the response cycle.
  assign previous = m_load_s ? load_align(m_funct3_q, m_result_q[1:0], dmem_resp_data)
                             : m_result_q;
  assign prev_rd  = m_rd_q;

  // State and stage registers; reset abandons any access and inserts a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_ISSUE;
      m_valid_q      <= 1'b0;
      m_result_q     <= 32'h0000_0000;
      m_store_data_q <= 32'h0000_0000;
      m_rd_q         <= 5'd0;
      m_reg_we_q     <= 1'b0;
      m_is_load_q    <= 1'b0;
      m_is_store_q   <= 1'b0;
      m_funct3_q     <= 3'b000;
    end else begin
      state_q        <= state_d;
      m_valid_q      <= m_valid_d;
      m_result_q     <= m_result_d;
      m_store_data_q <= m_store_data_d;
      m_rd_q         <= m_rd_d;
      m_reg_we_q     <= m_reg_we_d;
      m_is_load_q    <= m_is_load_d;
      m_is_store_q   <= m_is_store_d;
      m_funct3_q     <= m_funct3_d;
    end
  end

endmodule

// File: tb/tb_mem_writeback.sv
// -----------------------------------------------------------------------------
// tb_mem_writeback -- scoreboard bench for mem_writeback.
// The driver pushes expected memory requests and writebacks when it presents an
// instruction; a negedge monitor pops and compares whenever the DUT shows an
// accepted request or a register write. A small memory model drives ready and
// returns load responses with configurable or random latency.
// -----------------------------------------------------------------------------
module tb_mem_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ex_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_we;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [2:0]  ex_funct3;
  logic        stall;
  logic        dmem_req_valid;
  logic        dmem_req_ready = 1'b1;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wmask;
  logic        dmem_resp_valid = 1'b0;
  logic [31:0] dmem_resp_data = 32'h0;
  logic [31:0] previous;
  logic [4:0]  prev_rd;
  logic        prev_reg_we;

  always #5 clk = ~clk;

  mem_writeback dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_funct3(ex_funct3),
    .stall(stall), .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
    .dmem_wmask(dmem_wmask), .dmem_resp_valid(dmem_resp_valid),
    .dmem_resp_data(dmem_resp_data), .previous(previous), .prev_rd(prev_rd),
    .prev_reg_we(prev_reg_we)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  wb_t         wb_q[$];
  req_t        req_q[$];
  logic [31:0] rdata_q[$];

  // memory model controls
  bit rand_mode     = 1'b0;
  int ready_low_cnt = 0;
  int fixed_delay   = 0;
  bit load_acc_n    = 1'b0;
  bit pending       = 1'b0;
  int wait_cnt      = 0;
  int resp_pulses   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int op_size(input logic [2:0] f3, input bit is_load);
    if (is_load) return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
  endfunction

  // Reference store: lanes [base, base+size) enabled, operand repeated per lane.
  function automatic logic [35:0] model_store(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] sd);
    int size = op_size(f3, 1'b0);
    int base = (int'(addr % 4) / size) * size;
    logic [31:0] wd;
    logic [3:0]  wm;
    for (int i = 0; i < 4; i++) begin
      wd[8*i +: 8] = sd[8*(i % size) +: 8];
      wm[i] = (i >= base) && (i < base + size);
    end
    return {wm, wd};
  endfunction

  // Reference load: shift, mask to access size, subtract 2^bits if negative.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] data);
    int size = op_size(f3, 1'b1);
    int base = (int'(addr % 4) / size) * size;
    logic [63:0] v;
    v = ({32'h0, data} >> (8*base)) & ((64'd1 << (8*size)) - 64'd1);
    if (size < 4 && !f3[2] && (((v >> (8*size - 1)) & 64'd1) == 64'd1))
      v = v - (64'd1 << (8*size));
    return v[31:0];
  endfunction

  // Present one instruction, record its expectations, wait until M takes it.
  task automatic issue(input bit ld, input bit st, input bit we, input logic [4:0] rd,
                       input logic [2:0] f3, input logic [31:0] res, input logic [31:0] sd,
                       input logic [31:0] rdata, input int lowcnt);
    req_t r;
    wb_t  w;
    logic [35:0] ms;
    int   guard;
    logic s;
    if (ld) begin
      rdata_q.push_back(rdata);
      r.addr = {res[31:2], 2'b00}; r.we = 1'b0; r.wdata = 32'h0; r.wmask = 4'h0;
      req_q.push_back(r);
      if (we && rd != 5'd0) begin w.rd = rd; w.data = model_load(f3, res, rdata); wb_q.push_back(w); end
    end else if (st) begin
      ms = model_store(f3, res, sd);
      r.addr = {res[31:2], 2'b00}; r.we = 1'b1; r.wdata = ms[31:0]; r.wmask = ms[35:32];
      req_q.push_back(r);
    end else if (we && rd != 5'd0) begin
      w.rd = rd; w.data = res; wb_q.push_back(w);
    end
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_reg_we = we; ex_rd = rd;
    ex_funct3 = f3; ex_result = res; ex_store_data = sd;
    guard = 0;
    do begin
      @(negedge clk);
      s = stall;
      if (!s) ready_low_cnt = lowcnt;
      @(posedge clk);
      #1;
      guard++;
    end while (s && guard < 100);
    if (s) begin
      checks++; errors++;
      $display("FAIL accept_timeout: stall still %b after %0d cycles", s, guard);
    end
    ex_valid = 1'b0;
  endtask

  // Wait for the writeback of the instruction just issued.
  task automatic wait_wb(input string name, input logic [31:0] exp, input int exp_stalls);
    int  n = 0;
    bit  got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (prev_reg_we) got = 1'b1;
      else if (stall) n++;
    end
    check({name, "_seen"}, 32'(got), 32'd1);
    check({name, "_data"}, previous, exp);
    check({name, "_stall"}, 32'(stall), 32'd0);
    check({name, "_stall_cycles"}, 32'(n), 32'(exp_stalls));
  endtask

  // Memory model: ready policy, load response latency, spurious responses.
  always @(posedge clk) begin
    #1;
    dmem_resp_valid = 1'b0;
    if (ready_low_cnt > 0) begin
      dmem_req_ready = 1'b0;
      ready_low_cnt--;
    end else if (rand_mode) begin
      dmem_req_ready = ($urandom_range(0, 3) != 0);
    end else begin
      dmem_req_ready = 1'b1;
    end
    if (load_acc_n) begin
      pending  = 1'b1;
      wait_cnt = rand_mode ? int'($urandom_range(0, 2)) : fixed_delay;
    end
    if (pending) begin
      if (wait_cnt == 0) begin
        dmem_resp_valid = 1'b1;
        dmem_resp_data  = (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'hDEAD_BEEF;
        pending = 1'b0;
        resp_pulses++;
      end else begin
        wait_cnt--;
      end
    end else if (rand_mode && $urandom_range(0, 7) == 0) begin
      dmem_resp_valid = 1'b1;
      dmem_resp_data  = $urandom;
    end
  end

  // Monitor: compare accepted requests and writebacks against the scoreboard.
  bit   held_v = 1'b0;
  req_t held;
  always @(negedge clk) begin
    req_t r;
    wb_t  w;
    if (!reset) begin
      if (held_v) begin
        check("req_hold_valid", 32'(dmem_req_valid), 32'd1);
        check("req_hold_addr", dmem_addr, held.addr);
        check("req_hold_wdata", dmem_wdata, held.wdata);
        check("req_hold_wmask", 32'(dmem_wmask), 32'(held.wmask));
      end
      if (dmem_req_valid && dmem_req_ready) begin
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: addr %h we %b with nothing expected", dmem_addr, dmem_we);
        end else begin
          r = req_q.pop_front();
          check("req_addr", dmem_addr, r.addr);
          check("req_we", 32'(dmem_we), 32'(r.we));
          if (r.we) begin
            check("req_wdata", dmem_wdata, r.wdata);
            check("req_wmask", 32'(dmem_wmask), 32'(r.wmask));
          end
        end
      end
      held_v = dmem_req_valid && !dmem_req_ready;
      held.addr = dmem_addr; held.we = dmem_we; held.wdata = dmem_wdata; held.wmask = dmem_wmask;
      if (prev_reg_we) begin
        if (wb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wb: rd %0d data %h with nothing expected", prev_rd, previous);
        end else begin
          w = wb_q.pop_front();
          check("wb_rd", 32'(prev_rd), 32'(w.rd));
          check("wb_data", previous, w.data);
        end
      end
      load_acc_n = dmem_req_valid && dmem_req_ready && !dmem_we;
    end else begin
      held_v     = 1'b0;
      load_acc_n = 1'b0;
    end
  end

  initial begin
    bit ld, st;
    // Reset with garbage on the execute side; it must not reach M.
    reset = 1'b1;
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0; ex_reg_we = 1'b1;
    ex_rd = 5'd9; ex_funct3 = 3'b010; ex_result = 32'hFFFF_FFFF; ex_store_data = 32'h1234_5678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req_valid", 32'(dmem_req_valid), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_wmask", 32'(dmem_wmask), 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_previous", previous, 32'd0);
    check("rst_prev_rd", 32'(prev_rd), 32'd0);
    check("rst_prev_we", 32'(prev_reg_we), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    ex_valid = 1'b0;
    repeat (2) @(posedge clk); #1;

    // ALU op, one-cycle writeback
    issue(1'b0, 1'b0, 1'b1, 5'd5, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 0);
    @(negedge clk);
    check("alu_previous", previous, 32'h0000_1234);
    check("alu_prev_rd", 32'(prev_rd), 32'd5);
    check("alu_prev_we", 32'(prev_reg_we), 32'd1);
    check("alu_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    issue(1'b0, 1'b0, 1'b1, 5'd0, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 0);
    @(negedge clk);
    check("alu_rd0_prev_we", 32'(prev_reg_we), 32'd0);
    @(posedge clk); #1;

    // SB with ready high
    issue(1'b0, 1'b1, 1'b0, 5'd0, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 32'h0, 0);
    @(negedge clk);
    check("sb_addr", dmem_addr, 32'h0000_1000);
    check("sb_wmask", 32'(dmem_wmask), 32'b1000);
    check("sb_wdata", dmem_wdata, 32'hDDDD_DDDD);
    check("sb_we", 32'(dmem_we), 32'd1);
    check("sb_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;

    // SH with ready low for three cycles
    issue(1'b0, 1'b1, 1'b0, 5'd0, 3'b001, 32'h0000_2002, 32'h1122_3344, 32'h0, 3);
    begin
      int n = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (!stall) break;
        n++;
      end
      check("sh_stall_cycles", 32'(n), 32'd3);
      check("sh_wmask", 32'(dmem_wmask), 32'b1100);
      check("sh_accept", 32'(dmem_req_valid & dmem_req_ready), 32'd1);
    end
    @(posedge clk); #1;

    // Loads: response two cycles after acceptance, then back-to-back fast ones
    fixed_delay = 1;
    issue(1'b1, 1'b0, 1'b1, 5'd3, 3'b000, 32'h0000_3001, 32'h0, 32'h0000_8000, 0);
    wait_wb("lb", 32'hFFFF_FF80, 2);
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 1'b1, 5'd4, 3'b100, 32'h0000_3001, 32'h0, 32'h0000_8000, 0);
    wait_wb("lbu", 32'h0000_0080, 2);
    @(posedge clk); #1;
    fixed_delay = 0;
    issue(1'b1, 1'b0, 1'b1, 5'd6, 3'b001, 32'h0000_4002, 32'h0, 32'h8001_0000, 0);
    wait_wb("lh", 32'hFFFF_8001, 1);
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 1'b1, 5'd8, 3'b010, 32'h0000_4004, 32'h0, 32'hCAFE_F00D, 0);
    wait_wb("lw", 32'hCAFE_F00D, 1);
    @(posedge clk); #1;

    // Reset while waiting for a load response
    fixed_delay = 4;
    resp_pulses = 0;
    issue(1'b1, 1'b0, 1'b1, 5'd7, 3'b010, 32'h0000_5000, 32'h0, 32'h5555_AAAA, 0);
    repeat (1) @(posedge clk); #1;
    reset = 1'b1;
    void'(wb_q.pop_back());
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rstwait_prev_we", 32'(prev_reg_we), 32'd0);
      check("rstwait_stall", 32'(stall), 32'd0);
    end
    check("rstwait_late_resp", 32'(resp_pulses), 32'd1);
    @(posedge clk); #1;
    fixed_delay = 0;
    issue(1'b0, 1'b0, 1'b1, 5'd12, 3'b000, 32'h0BAD_0001, 32'h0, 32'h0, 0);
    @(negedge clk);
    check("rstwait_alu_we", 32'(prev_reg_we), 32'd1);
    check("rstwait_alu_data", previous, 32'h0BAD_0001);
    @(posedge clk); #1;

    // Randomized traffic
    rand_mode = 1'b1;
    for (int k = 0; k < 300; k++) begin
      int kind = $urandom_range(0, 9);
      ld = (kind >= 4 && kind <= 6);
      st = (kind >= 7);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      issue(ld, st, (st ? 1'b0 : 1'($urandom_range(0, 5) != 0)), 5'($urandom_range(0, 31)),
            3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 0);
    end
    rand_mode = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("drain_wb_queue", 32'(wb_q.size()), 32'd0);
    check("drain_req_queue", 32'(req_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
